// File: rtl/decode_stage.sv
// Registered decode stage: classifies the opcode and extracts register fields behind a 2-entry skid buffer.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds out_illegal and a sticky halt on accepted illegal entries.
module decode_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            out_illegal
`endif
);

  // Encoding is {main_valid, skid_valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b10,
    StFull  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] main_instr_q, main_pc_q, skid_instr_q, skid_pc_q;
  logic [4:0]      main_type_q, skid_type_q;

  logic       main_valid;
  logic       in_xfer, out_xfer, cap;
  logic       load_main_new, load_main_skid, load_skid;
  logic [4:0] new_type;

  function automatic logic [4:0] decode_type(input logic [6:0] opcode);
    logic [4:0] t;
    case (opcode)
      7'b0110011: t = 5'd1;
      7'b0000011: t = 5'd2;
      7'b0010011: t = 5'd3;
      7'b1100111: t = 5'd4;
      7'b0100011: t = 5'd5;
      7'b1100011: t = 5'd6;
      7'b0110111: t = 5'd7;
      7'b0010111: t = 5'd8;
      7'b1101111: t = 5'd9;
      default:    t = 5'd0;
    endcase
    return t;
  endfunction

  assign main_valid = state_q[1];
  assign in_xfer    = in_valid & in_ready_q;
  assign out_xfer   = main_valid & out_ready;
  // Flush wins over a same-cycle capture.
  assign cap        = in_xfer & ~flush;
  assign new_type   = decode_type(in_instr[6:0]);

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic main_illegal_q, skid_illegal_q, new_illegal;
  logic halt_q, halt_d;

  assign new_illegal = (new_type == 5'd0) && (in_instr != '0);
  assign halt_d      = flush ? 1'b0 : (halt_q | (out_xfer & main_illegal_q));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q         <= 1'b0;
      main_illegal_q <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      if (load_main_new) begin
        main_illegal_q <= new_illegal;
      end else if (load_main_skid) begin
        main_illegal_q <= skid_illegal_q;
      end
      if (load_skid) begin
        skid_illegal_q <= new_illegal;
      end
    end
  end

  assign out_illegal = main_valid & main_illegal_q;
`endif

  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (cap) begin
            load_main_new = 1'b1;
            state_d       = StOne;
          end
        end
        StOne: begin
          if (cap && out_xfer) begin
            load_main_new = 1'b1;
          end else if (cap) begin
            load_skid = 1'b1;
            state_d   = StFull;
          end else if (out_xfer) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_xfer) begin
            load_main_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    in_ready_d = ~state_d[0] & ~halt_d;
`else
    in_ready_d = ~state_d[0];
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      main_instr_q <= '0;
      main_pc_q    <= RESET_PC;
      main_type_q  <= 5'd0;
      skid_instr_q <= '0;
      skid_pc_q    <= RESET_PC;
      skid_type_q  <= 5'd0;
    end else begin
      if (load_main_new) begin
        main_instr_q <= in_instr;
        main_pc_q    <= in_pc;
        main_type_q  <= new_type;
      end else if (load_main_skid) begin
        main_instr_q <= skid_instr_q;
        main_pc_q    <= skid_pc_q;
        main_type_q  <= skid_type_q;
      end
      if (load_skid) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
        skid_type_q  <= new_type;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_instr = main_instr_q;
  // Empty stage presents the reset PC and a bubble type.
  assign out_pc    = main_valid ? main_pc_q : RESET_PC;
  assign out_type  = main_valid ? main_type_q : 5'd0;
  assign out_rd    = main_instr_q[11:7];
  assign out_rs1   = main_instr_q[19:15];
  assign out_rs2   = main_instr_q[24:20];

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver pushes expected entries, monitor checks the output side.
module tb_decode_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [4:0]  out_type, out_rd, out_rs1, out_rs2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  decode_stage #(.XLEN(32), .RESET_PC(ResetPc)) dut (
    .CLK      (clk),
    .RST      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc   (out_pc),
    .out_type (out_type),
    .out_rd   (out_rd),
    .out_rs1  (out_rs1),
    .out_rs2  (out_rs2)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .out_illegal(out_illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  typ;
    logic        ill;
  } exp_t;

  exp_t q[$];
  bit   halted = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_type(input logic [6:0] op);
    logic [4:0] t;
    case (op)
      7'h33:   t = 5'd1;
      7'h03:   t = 5'd2;
      7'h13:   t = 5'd3;
      7'h67:   t = 5'd4;
      7'h23:   t = 5'd5;
      7'h63:   t = 5'd6;
      7'h37:   t = 5'd7;
      7'h17:   t = 5'd8;
      7'h6f:   t = 5'd9;
      default: t = 5'd0;
    endcase
    return t;
  endfunction

  function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.instr = ins;
    e.pc    = pc;
    e.typ   = ref_type(ins[6:0]);
    e.ill   = (e.typ == 5'd0) && (ins != 32'd0);
    return e;
  endfunction

  // Monitor: entries buffered in the model determine out_valid/in_ready; head of queue is on the outputs.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2) && !halted});
      if (!out_valid) begin
        chk("empty_type", {59'd0, out_type}, 64'd0);
        chk("empty_pc", {32'd0, out_pc}, {32'd0, ResetPc});
      end else if (q.size() != 0) begin
        chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
        chk("out_pc", {32'd0, out_pc}, {32'd0, q[0].pc});
        chk("out_type", {59'd0, out_type}, {59'd0, q[0].typ});
        chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].instr[11:7]});
        chk("out_rs1", {59'd0, out_rs1}, {59'd0, q[0].instr[19:15]});
        chk("out_rs2", {59'd0, out_rs2}, {59'd0, q[0].instr[24:20]});
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
        if (out_ready && q[0].ill) halted = 1'b1;
`endif
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ordy, input bit fl);
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = fl ? 1'b0 : ordy;
    flush     = fl;
    #4;
    if (fl) begin
      q.delete();
      halted = 1'b0;
    end else if (v && in_ready) begin
      q.push_back(mk(ins, pc));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  logic [6:0] ops [9] = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

  initial begin
    logic [31:0] r, r2, ins, pc;
    logic [6:0]  op;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single decode.
    cyc(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(2);
    // Streaming sw then jal.
    cyc(1'b1, 32'h0020_A423, 32'h104, 1'b1, 1'b0);
    cyc(1'b1, 32'h0100_00EF, 32'h108, 1'b1, 1'b0);
    idle(3);
    // Backpressure: three pushes with stalled consumer, then release.
    cyc(1'b1, 32'h0030_8133, 32'h200, 1'b0, 1'b0);
    cyc(1'b1, 32'h0041_2183, 32'h204, 1'b0, 1'b0);
    cyc(1'b1, 32'h0011_8663, 32'h208, 1'b0, 1'b0);
    cyc(1'b1, 32'h0011_8663, 32'h208, 1'b0, 1'b0);
    cyc(1'b1, 32'h0011_8663, 32'h208, 1'b1, 1'b0);
    cyc(1'b1, 32'h0011_8663, 32'h208, 1'b1, 1'b0);
    idle(4);
    // Flush in FULL with a competing capture.
    cyc(1'b1, 32'h1234_5037, 32'h300, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_1017, 32'h304, 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_8067, 32'h308, 1'b0, 1'b1);
    idle(3);
`ifdef DECODE_ILLEGAL_TRAP_EN
    cyc(1'b1, 32'h0000_007F, 32'h400, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0050_0093, 32'h404, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    idle(3);
`endif
    // Bubble word passes through as type 0.
    cyc(1'b1, 32'h0000_0000, 32'h500, 1'b1, 1'b0);
    idle(2);

    pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom();
      r2 = $urandom();
      op = ($urandom_range(0, 9) == 0) ? r2[6:0] : ops[$urandom_range(0, 8)];
      ins = ($urandom_range(0, 30) == 0) ? 32'd0 : {r[31:7], op};
      cyc($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0);
      pc = pc + 32'd4;
    end
    idle(4);

    // Asynchronous reset mid-cycle with two entries buffered.
    cyc(1'b1, 32'h0050_0093, 32'h600, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_A423, 32'h604, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_pc", {32'd0, out_pc}, {32'd0, ResetPc});
    chk("rst_out_type", {59'd0, out_type}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr}, 64'd0);
    q.delete();
    halted = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
